// File: rtl/puf_uart_ctrl_if.sv
// Signal bundle between the PUF protocol controller and its environment
// (UART wrapper on one side, PUF core on the other).
interface puf_uart_ctrl_if #(
  parameter int DATA_BITS  = 8,
  parameter int CHAL_BYTES = 8,
  parameter int RESP_BYTES = 4
);
  logic [DATA_BITS-1:0]            rx_data;
  logic                            rx_valid;
  logic                            rx_enable;
  logic [DATA_BITS-1:0]            tx_data;
  logic                            tx_enable;
  logic                            tx_busy;
  logic [CHAL_BYTES*DATA_BITS-1:0] challenge;
  logic                            puf_start;
  logic                            puf_done;
  logic [RESP_BYTES*DATA_BITS-1:0] puf_response;
  logic                            busy;
  logic                            frame_drop;

  // Controller side
  modport slave (
    input  rx_data, rx_valid, tx_busy, puf_done, puf_response,
    output rx_enable, tx_data, tx_enable, challenge, puf_start, busy, frame_drop
  );

  // Environment side (UART wrapper + PUF core)
  modport master (
    output rx_data, rx_valid, tx_busy, puf_done, puf_response,
    input  rx_enable, tx_data, tx_enable, challenge, puf_start, busy, frame_drop
  );
endinterface

// File: rtl/puf_uart_ctrl.sv
// Byte-level protocol controller: header detect, challenge assembly,
// PUF launch, and MSB-first serialisation of the response into the UART.
module puf_uart_ctrl #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   CHAL_BYTES     = 8,
  parameter int                   RESP_BYTES     = 4,
  parameter logic [DATA_BITS-1:0] HEADER         = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 5_000_000
) (
  input  logic           clk,
  input  logic           areset,
  puf_uart_ctrl_if.slave bus
);
  localparam int CW      = CHAL_BYTES * DATA_BITS;
  localparam int RW      = RESP_BYTES * DATA_BITS;
  localparam int CNT_MAX = (CHAL_BYTES > RESP_BYTES) ? CHAL_BYTES : RESP_BYTES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CHAL_LAST = CNT_W'(CHAL_BYTES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RX_CHAL, START, WAIT_PUF, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [CW-1:0]        chal_q, chal_d;
  logic [RW-1:0]        resp_q, resp_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 puf_start_q, puf_start_d;
  logic                 tx_enable_q, tx_enable_d;
  logic                 frame_drop_q, frame_drop_d;
  int                   sel_base;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    to_cnt_d     = to_cnt_q;
    chal_d       = chal_q;
    resp_d       = resp_q;
    tx_data_d    = tx_data_q;
    puf_start_d  = 1'b0;
    tx_enable_d  = 1'b0;
    frame_drop_d = 1'b0;
    sel_base     = (RESP_BYTES - 1 - int'(byte_cnt_q)) * DATA_BITS;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == HEADER) begin
          state_d    = RX_CHAL;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      RX_CHAL: begin
        // A byte arriving on the limit cycle still counts: rx_valid is tested first.
        if (bus.rx_valid) begin
          chal_d   = {chal_q[CW-DATA_BITS-1:0], bus.rx_data};
          to_cnt_d = '0;
          if (byte_cnt_q == CHAL_LAST) begin
            state_d     = START;
            puf_start_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (to_cnt_q == TO_LIMIT) begin
          frame_drop_d = 1'b1;
          state_d      = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      START: state_d = WAIT_PUF;
      WAIT_PUF: begin
        if (bus.puf_done) begin
          resp_d     = bus.puf_response;
          byte_cnt_d = '0;
          // Launch the first byte straight from the PUF result when the UART is
          // idle, so tx_enable lands one cycle after puf_done.
          if (!bus.tx_busy) begin
            tx_data_d   = bus.puf_response[RW-1 -: DATA_BITS];
            tx_enable_d = 1'b1;
            state_d     = TX_WAIT_HI;
          end else begin
            state_d = TX_LOAD;
          end
        end
      end
      TX_LOAD: begin
        if (!bus.tx_busy) begin
          tx_data_d   = resp_q[sel_base +: DATA_BITS];
          tx_enable_d = 1'b1;
          state_d     = TX_WAIT_HI;
        end
      end
      // Wait for the UART to acknowledge by raising busy before looking for idle.
      TX_WAIT_HI: if (bus.tx_busy) state_d = TX_WAIT_LO;
      TX_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (byte_cnt_q == RESP_LAST) begin
            state_d = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = TX_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
      chal_q       <= '0;
      resp_q       <= '0;
      tx_data_q    <= '0;
      puf_start_q  <= 1'b0;
      tx_enable_q  <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      to_cnt_q     <= to_cnt_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      tx_data_q    <= tx_data_d;
      puf_start_q  <= puf_start_d;
      tx_enable_q  <= tx_enable_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign bus.rx_enable  = (state_q == IDLE) || (state_q == RX_CHAL);
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_enable  = tx_enable_q;
  assign bus.challenge  = chal_q;
  assign bus.puf_start  = puf_start_q;
  assign bus.frame_drop = frame_drop_q;
endmodule

// File: tb/tb_puf_uart_ctrl.sv
// Scoreboard bench for puf_uart_ctrl: frame-level reference model feeds
// expectation queues, a monitor pops them as the DUT emits events.
module tb_puf_uart_ctrl;
  localparam int         DB  = 8;
  localparam int         CB  = 8;
  localparam int         RB  = 4;
  localparam int         TO  = 100;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  puf_uart_ctrl_if #(.DATA_BITS(DB), .CHAL_BYTES(CB), .RESP_BYTES(RB)) bus();

  puf_uart_ctrl #(
    .DATA_BITS(DB), .CHAL_BYTES(CB), .RESP_BYTES(RB),
    .HEADER(HDR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .areset(areset), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_chal_q[$];
  logic [31:0] puf_resp_q[$];
  logic [7:0]  exp_tx_q[$];
  int drops_seen = 0, drops_exp = 0, tx_en_cnt = 0;
  int tx_dly = 1, tx_hold = 8;
  bit tx_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Monitor: compare every DUT event against the scoreboard queues
  always @(posedge clk) begin
    #1;
    if (bus.tx_busy) tx_pending = 1'b0;
    if (bus.puf_start) begin
      if (exp_chal_q.size() == 0) fail("puf_start_unexpected");
      else chk("challenge_at_start", bus.challenge, exp_chal_q.pop_front());
      chk("rx_enable_in_start", bus.rx_enable, 0);
    end
    if (bus.tx_enable) begin
      tx_en_cnt++;
      if (exp_tx_q.size() == 0) fail("tx_enable_unexpected");
      else chk("tx_byte", bus.tx_data, exp_tx_q.pop_front());
      chk("tx_enable_while_busy", bus.tx_busy, 0);
      chk("tx_double_send", tx_pending, 0);
      tx_pending = 1'b1;
    end
    if (bus.frame_drop) begin
      drops_seen++;
      chk("drop_returns_idle", bus.busy, 0);
    end
  end

  // UART transmitter model: busy rises tx_dly cycles after a send, holds tx_hold
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_enable) begin
        repeat (tx_dly - 1) @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (tx_hold) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  // PUF model: answers 20 cycles after start with the next queued response
  initial begin
    logic [31:0] r;
    bus.puf_done = 1'b0;
    bus.puf_response = '0;
    forever begin
      @(negedge clk);
      if (bus.puf_start) begin
        r = (puf_resp_q.size() != 0) ? puf_resp_q.pop_front() : 32'h0;
        repeat (19) @(negedge clk);
        bus.puf_response = r;
        bus.puf_done = 1'b1;
        @(negedge clk);
        bus.puf_done = 1'b0;
        bus.puf_response = $urandom;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Reference model: challenge is the byte stream in arrival order, response goes out MSB first
  task automatic push_frame(input logic [63:0] chal, input logic [31:0] resp);
    exp_chal_q.push_back(chal);
    puf_resp_q.push_back(resp);
    for (int i = 0; i < RB; i++) exp_tx_q.push_back(resp[8*(RB-1-i) +: 8]);
  endtask

  task automatic send_chal(input logic [63:0] chal, input int gap_max, input int big_gap_at);
    send_byte(HDR);
    for (int i = 0; i < CB; i++) begin
      idle((i == big_gap_at) ? TO - 1 : $urandom_range(0, gap_max));
      send_byte(chal[8*(CB-1-i) +: 8]);
    end
  endtask

  task automatic wait_done(input bit noise);
    bit ok = 1'b0;
    bit viol = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      if (bus.rx_enable) viol = 1'b1;
      if (noise && !bus.rx_enable && $urandom_range(0, 2) == 0) begin
        bus.rx_data  = $urandom;
        bus.rx_valid = 1'b1;
      end
    end
    chk("frame_completes", ok, 1);
    chk("rx_enable_low_after_chal", viol, 0);
  endtask

  task automatic run_frame(input logic [63:0] chal, input logic [31:0] resp, input int garbage,
                           input int gap_max, input int big_gap_at, input bit noise);
    logic [7:0] g;
    push_frame(chal, resp);
    for (int i = 0; i < garbage; i++) begin
      g = $urandom;
      if (g == HDR) g = 8'h00;
      send_byte(g);
    end
    send_chal(chal, gap_max, big_gap_at);
    wait_done(noise);
    chk("challenge_held", bus.challenge, chal);
    chk("tx_queue_drained", exp_tx_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rx_enable"}, bus.rx_enable, 1);
    chk({tag, "_challenge"}, bus.challenge, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_pulses"}, {bus.puf_start, bus.tx_enable, bus.frame_drop}, 0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int base;
    bit seen;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    #1 areset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) areset = 1'b0;

    // Nominal frame
    tx_dly = 2; tx_hold = 6;
    run_frame(64'h0102030405060708, 32'hDEADBEEF, 0, 0, -1, 1'b0);

    // Bytes before the header
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA4);
    run_frame(rnd64(), $urandom, 0, 3, -1, 1'b0);

    // Inter-byte timeout, then recovery
    send_byte(HDR); send_byte(8'h11); send_byte(8'h22);
    idle(150);
    drops_exp++;
    chk("drop_count_timeout", drops_seen, drops_exp);
    chk("idle_after_drop", bus.busy, 0);
    run_frame(rnd64(), $urandom, 0, 5, -1, 1'b0);

    // Byte arriving exactly on the limit cycle is accepted
    run_frame(rnd64(), $urandom, 0, 2, 3, 1'b0);
    chk("no_drop_at_limit", drops_seen, drops_exp);
    // One cycle later is too late
    send_byte(HDR); send_byte(8'h33);
    idle(TO);
    idle(2);
    drops_exp++;
    chk("drop_past_limit", drops_seen, drops_exp);

    // Slow transmitter
    tx_dly = 3; tx_hold = 50;
    base = tx_en_cnt;
    run_frame(rnd64(), $urandom, 1, 4, -1, 1'b0);
    chk("slow_tx_enable_count", tx_en_cnt - base, RB);

    // Bytes injected during PUF and TX phases
    for (int k = 0; k < 2; k++) begin
      tx_dly = $urandom_range(1, 4); tx_hold = $urandom_range(2, 12);
      run_frame(rnd64(), $urandom, 0, 3, -1, 1'b1);
    end

    // Randomised frames
    for (int k = 0; k < 4; k++) begin
      tx_dly = $urandom_range(1, 4); tx_hold = $urandom_range(1, 12);
      run_frame(rnd64(), $urandom, $urandom_range(0, 3), $urandom_range(0, 20), -1, 1'b0);
    end

    // Reset while receiving the challenge
    send_byte(HDR); send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C);
    @(negedge clk) areset = 1'b1;
    #1 chk_reset("rst_rx_chal");
    @(negedge clk) areset = 1'b0;
    run_frame(rnd64(), $urandom, 0, 3, -1, 1'b0);

    // Reset while waiting for the UART to finish a byte
    tx_dly = 2; tx_hold = 20;
    push_frame(64'hCAFEF00D12345678, 32'h89ABCDEF);
    base = tx_en_cnt;
    send_chal(64'hCAFEF00D12345678, 2, -1);
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      if (tx_en_cnt > base && bus.tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_tx_wait_lo", seen, 1);
    idle(3);
    @(negedge clk) areset = 1'b1;
    #1 chk_reset("rst_tx_wait_lo");
    exp_tx_q.delete();
    @(negedge clk) areset = 1'b0;
    run_frame(rnd64(), $urandom, 0, 3, -1, 1'b0);

    idle(5);
    chk("chal_queue_empty", exp_chal_q.size(), 0);
    chk("resp_queue_empty", puf_resp_q.size(), 0);
    chk("drop_count_final", drops_seen, drops_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/puf_uart_ctrl.md
Name: puf_uart_ctrl

Overview:
Byte-level protocol controller between the UART wrapper (uart) and the PUF core. It consumes received bytes, recognises a header, and assembles a challenge word. It then fires the PUF and waits for its result. The response word is serialised byte-by-byte into the UART transmitter, using the tx_busy handshake.

Parameters:
DATA_BITS, 8, UART payload width in bits.
CHAL_BYTES, 8, challenge length in bytes; challenge width = CHAL_BYTES*DATA_BITS.
RESP_BYTES, 4, response length in bytes; response width = RESP_BYTES*DATA_BITS.
HEADER, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 5_000_000, maximum clk cycles allowed between challenge bytes (100 ms at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz
areset  input  1  asynchronous active-high reset
rx_data  input  DATA_BITS  byte from uart data_in
rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle
rx_enable  output  1  to uart rx_enable
tx_data  output  DATA_BITS  to uart data_out
tx_enable  output  1  one-cycle send request to uart
tx_busy  input  1  from uart tx_busy
challenge  output  CHAL_BYTES*DATA_BITS  challenge to the PUF
puf_start  output  1  one-cycle start pulse
puf_done  input  1  one-cycle pulse; puf_response is valid in that cycle
puf_response  input  RESP_BYTES*DATA_BITS  PUF result
busy  output  1  high in any state other than IDLE
frame_drop  output  1  one-cycle pulse on inter-byte timeout

Behaviour:
- Clock and reset: one clock domain (clk). areset is asynchronous and active-high.
- Reset state:
  - FSM is in IDLE.
  - Byte counter, timeout counter, challenge register, response register and tx_data are 0.
  - puf_start, tx_enable, frame_drop and busy are 0.
  - rx_enable is 1.
- rx_enable is decoded from state: 1 in IDLE and RX_CHAL, 0 elsewhere. rx_valid is ignored in all other states.
- IDLE:
  - rx_valid with rx_data==HEADER -> RX_CHAL; byte_cnt=0; timeout counter=0.
  - Any other byte is discarded and the FSM stays in IDLE.
- RX_CHAL:
  - On rx_valid, shift the byte in: challenge <= {challenge[W-DATA_BITS-1:0], rx_data}. The first received byte becomes the MSB byte.
  - The timeout counter clears on each rx_valid.
  - On rx_valid when byte_cnt==CHAL_BYTES-1 -> START.
  - A header value received in RX_CHAL is data, not a resync.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no rx_valid: frame_drop pulses for 1 cycle -> IDLE. The partial challenge register is left as-is and is not guaranteed.
  - rx_valid in the same cycle the counter reaches its limit wins: the byte is accepted and no drop occurs.
- START:
  - puf_start=1 for exactly one cycle -> WAIT_PUF.
  - challenge is held stable from START until the next accepted header.
- WAIT_PUF:
  - On puf_done, latch puf_response into the response register -> TX_LOAD; byte_cnt=0.
  - No timeout applies in this state.
  - puf_done in any other state is ignored.
- TX_LOAD:
  - Wait for tx_busy==0.
  - In that cycle: tx_data = response byte selected by byte_cnt, MSB byte first; tx_enable=1 for one cycle -> TX_WAIT_HI.
  - tx_data stays stable until the next TX_LOAD.
- TX_WAIT_HI: wait for tx_busy==1 -> TX_WAIT_LO. This prevents a double send while uart has not yet raised busy.
- TX_WAIT_LO:
  - Wait for tx_busy==0.
  - If byte_cnt==RESP_BYTES-1 -> IDLE; otherwise byte_cnt+1 -> TX_LOAD.
- Latency:
  - puf_start is asserted 1 cycle after the rx_valid of the last challenge byte.
  - The first tx_enable is asserted 1 cycle after puf_done, provided tx_busy==0.
- Reset mid-operation: areset in any state returns immediately to the reset values above. An in-flight byte in uart is not tracked; the next frame starts clean.
- Counters:
  - byte_cnt width = $clog2(max(CHAL_BYTES,RESP_BYTES)).
  - Timeout counter width = $clog2(TIMEOUT_CYCLES). It saturates at its limit and does not wrap.
- All outputs are registered except rx_enable and busy, which are state decodes.

Test Plan:
1. Nominal frame (CHAL_BYTES=8, RESP_BYTES=4).
   - Stimulus: send A5 followed by 01..08; PUF model returns 32'hDEADBEEF 20 cycles after puf_start.
   - Required: challenge==64'h0102030405060708; exactly one puf_start pulse; tx bytes DE,AD,BE,EF in order; busy falls after the last byte completes.
2. Bytes before the header.
   - Stimulus: send 00,FF,A4, then a valid frame.
   - Required: the first three bytes are ignored; the frame is processed normally; exactly one puf_start pulse.
3. Inter-byte timeout (TIMEOUT_CYCLES=100).
   - Stimulus: send A5,11,22, then wait 150 cycles.
   - Required: one frame_drop pulse; FSM back in IDLE; no puf_start; a following complete frame succeeds.
4. Slow transmitter.
   - Stimulus: tx_busy rises 3 cycles after tx_enable and stays high 50 cycles per byte.
   - Required: exactly 4 tx_enable pulses; each pulse occurs only while tx_busy==0; no two pulses occur without an intervening tx_busy high period.
5. Bytes during PUF/TX.
   - Stimulus: inject rx_valid pulses while in WAIT_PUF and while in the TX states.
   - Required: rx_enable==0 throughout; challenge is unchanged; the response is still correct.
6. Reset mid-operation.
   - Stimulus: assert areset in RX_CHAL and, separately, in TX_WAIT_LO.
   - Required: all outputs return to reset values in the same cycle; the next full frame works end-to-end.
